// File: rtl/lut_n_pkg.sv
// Shared constants and the corner tables for the drive-period -> tuning-state lookup.
// Tables are elaboration-time constants: each instance folds its own table into comparators.
package lut_n_pkg;

  localparam int NW          = 14;
  localparam int SW          = 7;
  localparam int N_MIN       = 666;
  localparam int N_MAX       = 5000;
  localparam int N_CORNERS   = (1 << SW) - 1;
  localparam int ID_SERIES   = 1;
  localparam int ID_PARALLEL = 2;

  typedef logic [NW-1:0] cnt_t;
  typedef logic [SW-1:0] state_t;

  // CORNER[k] is the period at which state k begins; strictly descending in k.
  // Series spans 5000..667, parallel spans 4900..700; every step is >= 33 counts.
  function automatic cnt_t corner(input integer id, input integer k);
    integer v;
    v = 0;
    if (k >= 1 && k <= N_CORNERS) begin
      case (id)
        ID_SERIES:   v = N_MAX - ((k - 1) * 4333) / (N_CORNERS - 1);
        ID_PARALLEL: v = 4900  - ((k - 1) * 4200) / (N_CORNERS - 1);
        default:     v = 0;
      endcase
    end
    return v[NW-1:0];
  endfunction

  function automatic bit lookup_enabled(input integer id);
    return (id == ID_SERIES) || (id == ID_PARALLEL);
  endfunction

endpackage

// File: rtl/lut_n_thermo_to_bin.sv
// Thermometer-to-binary encoder: counts the set bits of a (2^SW - 1)-bit compare vector.
// A popcount rather than a priority encoder, so a stray bubble still lands on a sane state.
module thermo_to_bin #(
  parameter int SW = 7
) (
  input  logic [(1<<SW)-2:0] thermo,
  output logic [SW-1:0]      bin
);

  localparam int NT = (1 << SW) - 1;

  always_comb begin
    bin = '0;
    for (int i = 0; i < NT; i++) begin
      bin = bin + SW'(thermo[i]);
    end
  end

endmodule

// File: rtl/lut_n.sv
// Drive-period to capacitor-bank tuning-state lookup, one corner table per instance.
// Thermometer compare against constant corners, popcount, one output register.
module lut_n #(
  parameter int LOOKUP_ID = 1,
  parameter int NW        = 14,
  parameter int SW        = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NW-1:0] n_clk_cnts,
  output logic [SW-1:0] state
);

  import lut_n_pkg::*;

  localparam int NK = (1 << SW) - 1;

  if (lookup_enabled(LOOKUP_ID)) begin : g_lut
    logic [NK-1:0] thermo;
    logic [SW-1:0] next_state;

    // Bit k-1 set when n lies below CORNER[k]; descending corners make this a thermometer.
    for (genvar k = 1; k <= NK; k++) begin : g_cmp
      localparam logic [NW-1:0] CK = NW'(corner(LOOKUP_ID, k));
      assign thermo[k-1] = n_clk_cnts < CK;
    end

    thermo_to_bin #(.SW(SW)) u_t2b (
      .thermo (thermo),
      .bin    (next_state)
    );

    // A zero count means no measurement: hold the bank rather than slew it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        state <= '0;
      else if (n_clk_cnts != '0)
        state <= next_state;
    end
  end else begin : g_off
    logic unused_inputs;
    assign unused_inputs = clk ^ rst ^ (^n_clk_cnts);
    assign state = '0;
  end

endmodule

// File: tb/tb_lut_n.sv
// Bench for lut_n: series, parallel and disabled instances sharing one period input.
// Expected states come from a bench-side table and a linear-search golden lookup.
module tb_lut_n;

  logic        clk;
  logic        rst;
  logic [13:0] n;
  logic [6:0]  s1, s2, s3;

  lut_n #(.LOOKUP_ID(1), .NW(14), .SW(7)) u1 (.clk(clk), .rst(rst), .n_clk_cnts(n), .state(s1));
  lut_n #(.LOOKUP_ID(2), .NW(14), .SW(7)) u2 (.clk(clk), .rst(rst), .n_clk_cnts(n), .state(s2));
  lut_n #(.LOOKUP_ID(3), .NW(14), .SW(7)) u3 (.clk(clk), .rst(rst), .n_clk_cnts(n), .state(s3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;
  int c1 [1:127];
  int c2 [1:127];
  int m1, m2;
  int q1 [$];
  int q2 [$];
  int q3 [$];

  typedef struct {
    int n;
    int e1;
    int e2;
  } vec_t;
  vec_t vecs [$];

  function automatic int lookup(input int id, input int nv);
    for (int k = 127; k >= 1; k--) begin
      if (id == 1 && nv < c1[k]) return k;
      if (id == 2 && nv < c2[k]) return k;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (n=%0d t=%0t)", name, act, exp, n, $time);
  endtask

  task automatic drive_exp(input int nv, input int e1, input int e2);
    n = nv[13:0];
    m1 = e1;
    m2 = e2;
    q1.push_back(e1);
    q2.push_back(e2);
    q3.push_back(0);
    @(posedge clk);
    #1;
    chk("series", int'(s1), q1.pop_front());
    chk("parallel", int'(s2), q2.pop_front());
    chk("disabled", int'(s3), q3.pop_front());
  endtask

  task automatic drive(input int nv);
    if (nv == 0) drive_exp(nv, m1, m2);
    else drive_exp(nv, lookup(1, nv), lookup(2, nv));
  endtask

  initial begin
    int p1, p2, gold_diff, dut_diff;
    for (int k = 1; k <= 127; k++) begin
      c1[k] = 5000 - ((k - 1) * 4333) / 126;
      c2[k] = 4900 - ((k - 1) * 4200) / 126;
    end

    // Boundary and saturation vectors; series-table constants written out explicitly.
    vecs.push_back('{16383, 0,   0});
    vecs.push_back('{1,     127, 127});
    vecs.push_back('{5000,  0,   0});
    vecs.push_back('{666,   127, 127});
    vecs.push_back('{c1[1],       0,   lookup(2, c1[1])});
    vecs.push_back('{c1[1] - 1,   1,   lookup(2, c1[1] - 1)});
    vecs.push_back('{c1[64],      63,  lookup(2, c1[64])});
    vecs.push_back('{c1[64] - 1,  64,  lookup(2, c1[64] - 1)});
    vecs.push_back('{c1[127],     126, lookup(2, c1[127])});
    vecs.push_back('{c1[127] - 1, 127, lookup(2, c1[127] - 1)});
    vecs.push_back('{c2[1],       lookup(1, c2[1]),       0});
    vecs.push_back('{c2[1] - 1,   lookup(1, c2[1] - 1),   1});
    vecs.push_back('{c2[64],      lookup(1, c2[64]),      63});
    vecs.push_back('{c2[64] - 1,  lookup(1, c2[64] - 1),  64});
    vecs.push_back('{c2[127],     lookup(1, c2[127]),     126});
    vecs.push_back('{c2[127] - 1, lookup(1, c2[127] - 1), 127});

    // Reset held with a live measurement present.
    rst = 1'b1;
    n   = 14'd1000;
    m1  = 0;
    m2  = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_series", int'(s1), 0);
    chk("rst_parallel", int'(s2), 0);
    chk("rst_disabled", int'(s3), 0);
    rst = 1'b0;
    drive(1000);

    foreach (vecs[i]) drive_exp(vecs[i].n, vecs[i].e1, vecs[i].e2);

    // Zero count holds the previous state.
    drive_exp(c1[55] - 1, 55, lookup(2, c1[55] - 1));
    drive_exp(0, 55, lookup(2, c1[55] - 1));
    drive_exp(0, 55, lookup(2, c1[55] - 1));

    // Downward sweep with an asynchronous reset at n=2000.
    gold_diff = 0;
    dut_diff  = 0;
    drive(5000);
    p1 = int'(s1);
    p2 = int'(s2);
    for (int v = 4999; v >= 666; v--) begin
      drive(v);
      chk("mono_dn_series", int'(s1 >= 7'(p1)), 1);
      chk("mono_dn_parallel", int'(s2 >= 7'(p2)), 1);
      if (m1 != m2) gold_diff++;
      if (s1 != s2) dut_diff++;
      p1 = int'(s1);
      p2 = int'(s2);
      if (v == 2000) begin
        #2 rst = 1'b1;
        #1;
        chk("async_rst_series", int'(s1), 0);
        chk("async_rst_parallel", int'(s2), 0);
        chk("async_rst_disabled", int'(s3), 0);
        m1 = 0;
        m2 = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        p1 = 0;
        p2 = 0;
      end
    end

    // Upward sweep back to the low-frequency end.
    for (int v = 667; v <= 5000; v++) begin
      drive(v);
      chk("mono_up_series", int'(s1 <= 7'(p1)), 1);
      chk("mono_up_parallel", int'(s2 <= 7'(p2)), 1);
      if (m1 != m2) gold_diff++;
      if (s1 != s2) dut_diff++;
      p1 = int'(s1);
      p2 = int'(s2);
    end
    chk("table_diff_cycles", dut_diff, gold_diff);
    chk("tables_differ_somewhere", int'(dut_diff > 0), 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
